// File: rtl/nv_nvdla_mcif_read_eg_lat_credit_arb.sv
// Credit-gated round-robin arbiter in front of the MCIF read-egress latency FIFO.
// Optional build macro NVDLA_LAT_CREDIT_PRIO_EN gives client 0 strict priority.
module nv_nvdla_mcif_read_eg_lat_credit_arb #(
    parameter int NUM_CLIENTS = 4,
    parameter int ID_W        = 2,
    parameter int CREDITS     = 4,
    parameter int CNT_W       = 3,
    parameter int PD_W        = 79
) (
    input  logic                        nvdla_core_clk,
    input  logic                        nvdla_core_rstn,
    input  logic [NUM_CLIENTS-1:0]      clt_req_valid,
    input  logic [NUM_CLIENTS*PD_W-1:0] clt_req_pd,
    output logic [NUM_CLIENTS-1:0]      clt_req_ready,
    output logic                        dma_req_valid,
    input  logic                        dma_req_ready,
    output logic [PD_W-1:0]             dma_req_pd,
    output logic [ID_W-1:0]             dma_req_id,
    input  logic                        lat_fifo_pop,
    output logic [CNT_W-1:0]            credit_avail,
    output logic                        credit_err
);

    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        rr_next;
    logic                   err_next;
    logic [NUM_CLIENTS-1:0] elig;
    logic [ID_W-1:0]        win;
    logic                   win_found;
    logic [PD_W-1:0]        win_pd;
    logic                   slot_free;
    logic                   grant;

    // Winner search: first eligible client at or after rr_ptr, wrapping.
    always_comb begin
        elig      = clt_req_valid;
        win       = '0;
        win_found = 1'b0;
`ifdef NVDLA_LAT_CREDIT_PRIO_EN
        if (clt_req_valid[0]) begin
            win_found = 1'b1;
        end
        elig[0] = 1'b0;
`endif
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (!win_found && elig[i] &&
                    (i == ((int'(rr_ptr) + k) % NUM_CLIENTS))) begin
                    win_found = 1'b1;
                    win       = ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        win_pd = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (int'(win) == i) begin
                win_pd = clt_req_pd[i*PD_W +: PD_W];
            end
        end
    end

    assign slot_free = !dma_req_valid || dma_req_ready;
    assign grant     = slot_free && (cnt != '0) && win_found;

    // Ready is masked by reset so clients never see a handshake while held in reset.
    always_comb begin
        clt_req_ready = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            clt_req_ready[i] = grant && nvdla_core_rstn && (int'(win) == i);
        end
    end

    always_comb begin
        rr_next = rr_ptr;
        if (grant) begin
`ifdef NVDLA_LAT_CREDIT_PRIO_EN
            if (win != '0) begin
                rr_next = (int'(win) == NUM_CLIENTS - 1) ? '0 : win + ID_W'(1);
            end
`else
            rr_next = (int'(win) == NUM_CLIENTS - 1) ? '0 : win + ID_W'(1);
`endif
        end
    end

    // A grant and a pop in the same cycle cancel; a pop at full credit is an error.
    always_comb begin
        cnt_next = cnt;
        err_next = credit_err;
        if (grant && !lat_fifo_pop) begin
            cnt_next = cnt - CNT_W'(1);
        end else if (!grant && lat_fifo_pop) begin
            if (cnt == CNT_W'(CREDITS)) begin
                err_next = 1'b1;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            cnt           <= CNT_W'(CREDITS);
            rr_ptr        <= '0;
            credit_err    <= 1'b0;
            dma_req_valid <= 1'b0;
            dma_req_pd    <= '0;
            dma_req_id    <= '0;
        end else begin
            cnt        <= cnt_next;
            rr_ptr     <= rr_next;
            credit_err <= err_next;
            if (grant) begin
                dma_req_valid <= 1'b1;
                dma_req_pd    <= win_pd;
                dma_req_id    <= win;
            end else if (slot_free) begin
                dma_req_valid <= 1'b0;
            end
        end
    end

    assign credit_avail = cnt;

endmodule

// File: tb/tb_nv_nvdla_mcif_read_eg_lat_credit_arb.sv
// Directed self-checking bench for the latency-FIFO credit arbiter.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_nv_nvdla_mcif_read_eg_lat_credit_arb;

    localparam int NUM_CLIENTS = 4;
    localparam int ID_W        = 2;
    localparam int CREDITS     = 4;
    localparam int CNT_W       = 3;
    localparam int PD_W        = 79;

    logic                        clk = 1'b0;
    logic                        rstn = 1'b1;
    logic [NUM_CLIENTS-1:0]      clt_req_valid = '0;
    logic [NUM_CLIENTS*PD_W-1:0] clt_req_pd = '0;
    logic [NUM_CLIENTS-1:0]      clt_req_ready;
    logic                        dma_req_valid;
    logic                        dma_req_ready = 1'b0;
    logic [PD_W-1:0]             dma_req_pd;
    logic [ID_W-1:0]             dma_req_id;
    logic                        lat_fifo_pop = 1'b0;
    logic [CNT_W-1:0]            credit_avail;
    logic                        credit_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nv_nvdla_mcif_read_eg_lat_credit_arb #(
        .NUM_CLIENTS(NUM_CLIENTS), .ID_W(ID_W), .CREDITS(CREDITS),
        .CNT_W(CNT_W), .PD_W(PD_W)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .clt_req_valid  (clt_req_valid),
        .clt_req_pd     (clt_req_pd),
        .clt_req_ready  (clt_req_ready),
        .dma_req_valid  (dma_req_valid),
        .dma_req_ready  (dma_req_ready),
        .dma_req_pd     (dma_req_pd),
        .dma_req_id     (dma_req_id),
        .lat_fifo_pop   (lat_fifo_pop),
        .credit_avail   (credit_avail),
        .credit_err     (credit_err)
    );

    function automatic logic [PD_W-1:0] pd_of(input int i);
        return {15'(i + 5), 32'hFACE_0000, 32'(i * 3 + 1)};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rstn          = 1'b0;
        clt_req_valid = '1;
        dma_req_ready = 1'b1;
        lat_fifo_pop  = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) clt_req_pd[i*PD_W +: PD_W] = pd_of(i);
        #1;
        checks++;
        if (clt_req_ready !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_ready got=%b exp=0000", clt_req_ready);
        end
        checks++;
        if (dma_req_valid !== 1'b0 || dma_req_id !== 2'd0 || dma_req_pd !== '0) begin
            errors++; $display("[TB] FAIL reset_dma got v=%b id=%0d pd=%h exp v=0 id=0 pd=0",
                               dma_req_valid, dma_req_id, dma_req_pd);
        end
        checks++;
        if (credit_avail !== 3'd4 || credit_err !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_credit got avail=%0d err=%b exp avail=4 err=0",
                               credit_avail, credit_err);
        end
        @(negedge clk);
        rstn          = 1'b1;
        clt_req_valid = '0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        int         exp_id;
        int         exp_cr;
        test_reset();
        clt_req_valid = 4'hF;
        dma_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            lat_fifo_pop = (k >= 2);
`ifdef NVDLA_LAT_CREDIT_PRIO_EN
            exp_rdy = 4'b0001;
            exp_id  = 0;
`else
            exp_rdy = 4'(1 << (k % 4));
            exp_id  = (k + 3) % 4;
`endif
            exp_cr = (k == 0) ? 4 : ((k == 1) ? 3 : 2);
            #1;
            checks++;
            if (clt_req_ready !== exp_rdy) begin
                errors++; $display("[TB] FAIL rr_ready k=%0d got=%b exp=%b", k, clt_req_ready, exp_rdy);
            end
            checks++;
            if (credit_avail !== 3'(exp_cr)) begin
                errors++; $display("[TB] FAIL rr_credit k=%0d got=%0d exp=%0d", k, credit_avail, exp_cr);
            end
            if (k > 0) begin
                checks++;
                if (dma_req_valid !== 1'b1 || dma_req_id !== 2'(exp_id) || dma_req_pd !== pd_of(exp_id)) begin
                    errors++; $display("[TB] FAIL rr_dma k=%0d got v=%b id=%0d pd=%h exp v=1 id=%0d pd=%h",
                                       k, dma_req_valid, dma_req_id, dma_req_pd, exp_id, pd_of(exp_id));
                end
            end
            @(negedge clk);
        end
        lat_fifo_pop  = 1'b0;
        clt_req_valid = '0;
    endtask

    task automatic test_credit_exhaust();
        logic [3:0] exp_rdy;
        test_reset();
        clt_req_valid = 4'hF;
        dma_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef NVDLA_LAT_CREDIT_PRIO_EN
            exp_rdy = 4'b0001;
`else
            exp_rdy = 4'(1 << k);
`endif
            #1;
            checks++;
            if (clt_req_ready !== exp_rdy || credit_avail !== 3'(4 - k)) begin
                errors++; $display("[TB] FAIL exhaust_grant k=%0d got rdy=%b avail=%0d exp rdy=%b avail=%0d",
                                   k, clt_req_ready, credit_avail, exp_rdy, 4 - k);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (clt_req_ready !== 4'b0000 || credit_avail !== 3'd0) begin
            errors++; $display("[TB] FAIL exhaust_empty got rdy=%b avail=%0d exp rdy=0000 avail=0",
                               clt_req_ready, credit_avail);
        end
        @(negedge clk);
        lat_fifo_pop = 1'b1;
        #1;
        checks++;
        if (clt_req_ready !== 4'b0000 || dma_req_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL exhaust_pop_cycle got rdy=%b v=%b exp rdy=0000 v=0",
                               clt_req_ready, dma_req_valid);
        end
        @(negedge clk);
        lat_fifo_pop = 1'b0;
        #1;
        checks++;
        if (clt_req_ready !== 4'b0001 || credit_avail !== 3'd1) begin
            errors++; $display("[TB] FAIL exhaust_resume got rdy=%b avail=%0d exp rdy=0001 avail=1",
                               clt_req_ready, credit_avail);
        end
        @(negedge clk);
        #1;
        checks++;
        if (clt_req_ready !== 4'b0000 || credit_avail !== 3'd0 || dma_req_valid !== 1'b1 || dma_req_id !== 2'd0) begin
            errors++; $display("[TB] FAIL exhaust_one_more got rdy=%b avail=%0d v=%b id=%0d exp rdy=0000 avail=0 v=1 id=0",
                               clt_req_ready, credit_avail, dma_req_valid, dma_req_id);
        end
        clt_req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [PD_W-1:0] p1;
        logic [PD_W-1:0] p2;
        p1 = {15'h1111, 64'h0123_4567_89AB_CDEF};
        p2 = {15'h2222, 64'hDEAD_BEEF_0000_0001};
        test_reset();
        clt_req_pd[1*PD_W +: PD_W] = p1;
        clt_req_valid = 4'b0010;
        dma_req_ready = 1'b1;
        #1;
        checks++;
        if (clt_req_ready !== 4'b0010) begin
            errors++; $display("[TB] FAIL bp_first_grant got=%b exp=0010", clt_req_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            dma_req_ready = 1'b0;
            clt_req_pd[1*PD_W +: PD_W] = p2;
            clt_req_valid = 4'b0110;
            #1;
            checks++;
            if (dma_req_valid !== 1'b1 || dma_req_id !== 2'd1 || dma_req_pd !== p1 || clt_req_ready !== 4'b0000) begin
                errors++; $display("[TB] FAIL bp_hold k=%0d got v=%b id=%0d pd=%h rdy=%b exp v=1 id=1 pd=%h rdy=0000",
                                   k, dma_req_valid, dma_req_id, dma_req_pd, clt_req_ready, p1);
            end
        end
        @(negedge clk);
        dma_req_ready = 1'b1;
        #1;
        checks++;
        if (clt_req_ready !== 4'b0100) begin
            errors++; $display("[TB] FAIL bp_release_grant got=%b exp=0100", clt_req_ready);
        end
        @(negedge clk);
        clt_req_valid = '0;
        #1;
        checks++;
        if (dma_req_valid !== 1'b1 || dma_req_id !== 2'd2 || dma_req_pd !== pd_of(2) || credit_avail !== 3'd2) begin
            errors++; $display("[TB] FAIL bp_next got v=%b id=%0d pd=%h avail=%0d exp v=1 id=2 pd=%h avail=2",
                               dma_req_valid, dma_req_id, dma_req_pd, credit_avail, pd_of(2));
        end
        @(negedge clk);
    endtask

    task automatic test_grant_and_pop();
        test_reset();
        clt_req_valid = 4'b0001;
        dma_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        lat_fifo_pop = 1'b1;
        #1;
        checks++;
        if (credit_avail !== 3'd2 || clt_req_ready !== 4'b0001) begin
            errors++; $display("[TB] FAIL gp_before got avail=%0d rdy=%b exp avail=2 rdy=0001",
                               credit_avail, clt_req_ready);
        end
        @(negedge clk);
        lat_fifo_pop  = 1'b0;
        clt_req_valid = '0;
        #1;
        checks++;
        if (credit_avail !== 3'd2) begin
            errors++; $display("[TB] FAIL gp_after got avail=%0d exp avail=2", credit_avail);
        end
        @(negedge clk);
    endtask

    task automatic test_credit_err_and_reset();
        test_reset();
        lat_fifo_pop = 1'b1;
        @(negedge clk);
        lat_fifo_pop = 1'b0;
        #1;
        checks++;
        if (credit_avail !== 3'd4 || credit_err !== 1'b1) begin
            errors++; $display("[TB] FAIL err_set got avail=%0d err=%b exp avail=4 err=1", credit_avail, credit_err);
        end
        @(negedge clk);
        clt_req_valid = 4'hF;
        dma_req_ready = 1'b1;
        #1;
        checks++;
        if (credit_err !== 1'b1) begin
            errors++; $display("[TB] FAIL err_sticky got=%b exp=1", credit_err);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (dma_req_valid !== 1'b1 || credit_avail !== 3'd2) begin
            errors++; $display("[TB] FAIL midstream_pre got v=%b avail=%0d exp v=1 avail=2", dma_req_valid, credit_avail);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (dma_req_valid !== 1'b0 || credit_avail !== 3'd4 || credit_err !== 1'b0 || clt_req_ready !== 4'b0000) begin
            errors++; $display("[TB] FAIL midstream_reset got v=%b avail=%0d err=%b rdy=%b exp v=0 avail=4 err=0 rdy=0000",
                               dma_req_valid, credit_avail, credit_err, clt_req_ready);
        end
        @(negedge clk);
        rstn          = 1'b1;
        clt_req_valid = '0;
        @(negedge clk);
    endtask

`ifdef NVDLA_LAT_CREDIT_PRIO_EN
    task automatic test_priority();
        test_reset();
        clt_req_valid = 4'b0101;
        dma_req_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (clt_req_ready !== 4'b0001) begin
                errors++; $display("[TB] FAIL prio_c0 k=%0d got=%b exp=0001", k, clt_req_ready);
            end
            @(negedge clk);
        end
        clt_req_valid = 4'b0100;
        #1;
        checks++;
        if (clt_req_ready !== 4'b0100) begin
            errors++; $display("[TB] FAIL prio_c2 got=%b exp=0100", clt_req_ready);
        end
        @(negedge clk);
        clt_req_valid = '0;
        #1;
        checks++;
        if (dma_req_id !== 2'd2 || dma_req_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL prio_c2_dma got v=%b id=%0d exp v=1 id=2", dma_req_valid, dma_req_id);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_round_robin();
        test_credit_exhaust();
        test_backpressure();
        test_grant_and_pop();
        test_credit_err_and_reset();
`ifdef NVDLA_LAT_CREDIT_PRIO_EN
        test_priority();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
